// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

  localparam int CORDIC_LAT_DEFAULT = 17;
  localparam int DATA_W             = 32;

  // Q2.30 reference angles
  localparam logic [DATA_W-1:0] Q_ZERO     = 32'h0000_0000;
  localparam logic [DATA_W-1:0] Q_PI_4     = 32'h3243_f6a9;
  localparam logic [DATA_W-1:0] Q_NEG_PI_4 = 32'hcdbc_0957;
endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant
);
  logic            found;
  logic [ID_W-1:0] idx;

  // N_REQ is a power of two, so the ID_W-bit add wraps for free
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cordic_sched.sv
// Shares one fixed-latency CORDIC cosine engine among N_REQ requesters, round-robin.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int CORDIC_LAT = CORDIC_LAT_DEFAULT,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_angle,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [DATA_W-1:0]            resp_cos,
  output logic                         cordic_start,
  output logic [DATA_W-1:0]            cordic_angle,
  input  logic [DATA_W-1:0]            cordic_cos,
  output logic                         busy
);
  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, id_r, grant_id;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   angle_r;
  logic [N_REQ-1:0]    grant;
  logic                accept, last_cnt;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant)
  );

  assign req_ready    = (state == IDLE && !reset) ? grant : '0;
  assign accept       = |(req_valid & req_ready);
  assign last_cnt     = (cnt == CNT_W'(CORDIC_LAT - 1));
  assign cordic_start = (state == LOAD);
  assign cordic_angle = angle_r;
  assign busy         = (state != IDLE);

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) grant_id = ID_W'(i);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = LOAD;
      LOAD:                    state_nxt = BUSY;
      BUSY:    if (last_cnt)   state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The engine has no done flag; cos_out is sampled purely on the cycle count
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      id_r       <= '0;
      angle_r    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_cos   <= '0;
    end else begin
      if (accept) begin
        angle_r <= req_angle[grant_id];
        id_r    <= grant_id;
      end
      case (state)
        LOAD: cnt <= '0;
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (last_cnt) begin
            resp_cos   <= cordic_cos;
            resp_id    <= id_r;
            resp_valid <= 1'b1;
          end
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          rr_ptr     <= id_r + ID_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: fixed-latency engine stand-in plus a transaction-level reference model.
module tb_cordic_sched;
  import cordic_sched_pkg::*;
  localparam int N = 4, IW = 2, LAT = 17;

  logic                 clk = 1'b0, reset;
  logic [N-1:0]         req_valid, req_ready;
  logic [N-1:0][31:0]   req_angle;
  logic                 resp_valid, resp_ready, cordic_start, busy;
  logic [IW-1:0]        resp_id;
  logic [31:0]          resp_cos, cordic_angle, cordic_cos;

  always #5 clk = ~clk;

  cordic_sched #(.N_REQ(N), .ID_W(IW), .CORDIC_LAT(LAT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_cos(resp_cos), .cordic_start(cordic_start),
    .cordic_angle(cordic_angle), .cordic_cos(cordic_cos), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] cos_q(input logic [31:0] a);
    real r;
    r = real'($signed(a)) / 1073741824.0;
    return 32'($rtoi($cos(r) * 1073741824.0));
  endfunction

  function automatic bit near(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = $signed(a) - $signed(b);
    return (d <= 16) && (d >= -16);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Engine stand-in: junk while iterating, exact cosine once the latency has elapsed
  logic [4:0]  eng_it;
  logic [31:0] eng_ang, eng_out;
  always @(posedge clk) begin
    if (reset) begin
      eng_it <= '0; eng_out <= '0; eng_ang <= '0;
    end else if (cordic_start) begin
      eng_it <= 5'd1; eng_ang <= cordic_angle; eng_out <= 32'h0bad_0000;
    end else if (eng_it != 0) begin
      if (int'(eng_it) == LAT - 1) begin
        eng_out <= cos_q(eng_ang); eng_it <= '0;
      end else begin
        eng_it <= eng_it + 5'd1; eng_out <= 32'h0bad_0000 | 32'(eng_it);
      end
    end
  end
  assign cordic_cos = eng_out;

  // Reference model: one job at a time, response LAT+1 edges after accept
  bit          m_busy = 0, m_resp = 0;
  int          m_ptr = 0, m_id = 0, m_age = 0, m_done = 0, hs_id = -1, g;
  logic [31:0] m_ang = '0, m_cos = '0;
  always @(posedge clk) begin
    hs_id = -1;
    if (reset) begin
      m_busy = 0; m_resp = 0; m_ptr = 0;
    end else if (m_resp) begin
      if (resp_ready) begin
        m_resp = 0; m_busy = 0; m_ptr = (m_id + 1) % N; m_done++;
      end
    end else if (m_busy) begin
      m_age++;
      if (m_age == LAT + 1) begin m_resp = 1; m_cos = cos_q(m_ang); end
    end else begin
      g = rr_pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_busy = 1; m_id = g; m_ang = req_angle[g]; m_age = 0; hs_id = g;
      end
    end
  end

  bit           chk_en = 0;
  int           dut_order[$];
  int           g2;
  logic [N-1:0] e_rdy;
  logic [31:0]  ref_cos;
  always @(negedge clk) if (chk_en) begin
    e_rdy = '0;
    if (!m_busy && !reset) begin
      g2 = rr_pick(req_valid, m_ptr);
      if (g2 >= 0) e_rdy[g2] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(m_resp));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cordic_start", 32'(cordic_start), 32'(m_busy && !m_resp && m_age == 0));
    if (cordic_start) chk("cordic_angle", cordic_angle, m_ang);
    if (m_resp) begin
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_cos", resp_cos, m_cos);
      if (m_ang == Q_ZERO || m_ang == Q_PI_4 || m_ang == Q_NEG_PI_4) begin
        ref_cos = (m_ang == Q_ZERO) ? 32'h4000_0000 : 32'h2d41_3ccd;
        chk("cos_tol", 32'(near(resp_cos, ref_cos)), 32'd1);
      end
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i]) dut_order.push_back(i);
  end

  bit hold = 0, rnd = 0;
  task automatic tick();
    @(posedge clk); #1;
    if (hs_id >= 0 && !hold) req_valid[hs_id] = 1'b0;
    if (rnd) begin
      reset = ($urandom_range(399) == 0);
      resp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(3) == 0) begin req_valid[i] = 1'b1; req_angle[i] = $urandom; end
        end else begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
          if ($urandom_range(7) == 0)  req_angle[i] = $urandom;
        end
      end
    end
  endtask

  task automatic run_jobs(input int n);
    int tgt, c;
    tgt = m_done + n; c = 0;
    while (m_done < tgt && c < 400) begin tick(); c++; end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  int base;
  initial begin
    reset = 1'b1; req_valid = '0; req_angle = '0; resp_ready = 1'b1;
    tick(); chk_en = 1; tick();
    @(negedge clk);
    chk("rst_resp_cos", resp_cos, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_cordic_angle", cordic_angle, 32'h0);
    reset = 1'b0;

    // single request, angle 0
    req_angle[0] = Q_ZERO; req_valid = 4'b0001;
    run_jobs(1);

    // 1 and 3 contend from ptr 0, then 0 wins over a waiting 3
    do_reset();
    base = dut_order.size();
    req_angle[1] = Q_PI_4; req_angle[3] = Q_NEG_PI_4; req_valid = 4'b1010;
    run_jobs(2);
    req_angle[0] = $urandom; req_angle[3] = $urandom; req_valid = 4'b1001;
    run_jobs(1);
    chk("order_a0", 32'(dut_order[base]),   32'd1);
    chk("order_a1", 32'(dut_order[base+1]), 32'd3);
    chk("order_a2", 32'(dut_order[base+2]), 32'd0);
    run_jobs(1);
    req_valid = '0;

    // all four continuously valid at pi/4
    do_reset();
    base = dut_order.size();
    hold = 1; req_angle = {4{Q_PI_4}}; req_valid = 4'b1111;
    run_jobs(5);
    hold = 0; req_valid = '0;
    for (int i = 0; i < 5; i++) chk("order_b", 32'(dut_order[base+i]), 32'(i % 4));
    run_jobs(1);

    // backpressure for 30 cycles with another requester waiting
    do_reset();
    req_angle[2] = $urandom; req_valid = 4'b0100;
    for (int c = 0; c < 60 && !m_resp; c++) tick();
    resp_ready = 1'b0; req_angle[1] = $urandom; req_valid[1] = 1'b1;
    repeat (30) tick();
    resp_ready = 1'b1;
    run_jobs(2);

    // reset while BUSY with cnt=8, then a normal job
    do_reset();
    req_angle[1] = Q_PI_4; req_valid = 4'b0010;
    for (int c = 0; c < 60 && !(m_busy && m_age == 9); c++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'b0010;
    run_jobs(1);

    // angle changes after accept; a dropped requester is not served
    req_angle[3] = Q_ZERO; req_angle[0] = $urandom; req_valid = 4'b1001;
    tick();
    for (int c = 0; c < 10 && !m_busy; c++) tick();
    req_angle = {4{32'h1234_5678}}; req_valid = '0;
    run_jobs(1);
    repeat (5) tick();

    // randomized traffic with occasional resets
    rnd = 1;
    repeat (3000) tick();
    rnd = 0; reset = 1'b0; req_valid = '0; resp_ready = 1'b1;
    repeat (25) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
